sprite_engine: RTL and testbench
================================

# sprite_engine

Parametrised multi-sprite engine for the VGA pipeline. It holds NUM_SPRITES independently configured bouncing rectangles and advances their positions once per frame tick. It composites them per pixel with fixed index priority and reports per-pixel and per-frame overlap. It sits between the VGA low-level driver (X/Y, blanking) and the VGA client, and replaces the single fixed widget with a runtime-loadable set.

## Interface
- NUM_SPRITES, 4: number of sprite slots (1..16)
- COLOR_W, 4: bits per colour channel
- COORD_W, 11: width of X/Y pixel coordinates
- SIZE_W, 9: width of sprite width/height
- DEL_W, 5: width of per-tick step magnitude
- H_ACTIVE, 640 / V_ACTIVE, 480: visible area bounds
- CLK_100MHz  in  1  system clock, all logic rising-edge
- Reset  in  1  asynchronous, active-low reset
- X, Y  in  COORD_W  current pixel coordinate from the driver
- Blank  in  1  high during HBlank or VBlank
- Tick  in  1  one-cycle frame-advance strobe (clock divider pulse)
- CfgWe  in  1  load strobe for one slot
- CfgIdx  in  4  slot index to load
- CfgX, CfgY  in  COORD_W  initial position (top-left)
- CfgXSize, CfgYSize  in  SIZE_W  sprite dimensions, nonzero
- CfgDelX, CfgDelY  in  DEL_W  step magnitudes
- CfgRed, CfgGreen, CfgBlue  in  COLOR_W  sprite colour
- RED, GREEN, BLUE  out  COLOR_W  composited colour, 0 when no hit
- Hit  out  1  some enabled sprite covers the pixel
- HitIdx  out  4  index of winning sprite, 0 when no hit
- Collision  out  1  two or more sprites cover the pixel
- FrameCollision  out  1  sticky: a collision occurred since the last Tick

## Operation
- Per slot state: enable, x, y, xSize, ySize, delX, delY, dirX, dirY (0 = increasing), colour.
- Reset asserted: every slot is disabled, all fields are 0, both directions are 0, and every output is 0.
- CfgWe with CfgIdx < NUM_SPRITES loads all fields into the slot, sets enable to 1 and clears both directions. CfgIdx ≥ NUM_SPRITES is ignored.
- On Tick, each enabled slot moves per axis, computed in COORD_W+1 signed arithmetic:
  - When dir is 0: nx = x + delX. If nx ≥ H_ACTIVE − xSize, then x ← H_ACTIVE − xSize and dir ← 1. Otherwise x ← nx.
  - When dir is 1: nx = x − delX. If nx ≤ 0, then x ← 0 and dir ← 0. Otherwise x ← nx.
  - The Y axis follows the same rules using V_ACTIVE.
- A CfgWe and a Tick to the same slot in the same cycle: the config wins and no move occurs. Other slots still move.
- A slot's hit test is: enable & x ≤ X < x + xSize & y ≤ Y < y + ySize & !Blank.
- Priority: the lowest index wins. Collision = popcount(hits) ≥ 2.
- FrameCollision is set by any Collision. It is cleared by Tick. When set and clear coincide, set wins.

## Timing
- Compositing latency is 1 cycle. Outputs for the X/Y presented at cycle n are registered at edge n+1.
- Position updates take effect on the edge where Tick is sampled high. The hit test in the following cycle uses the new position.
- A config load is visible to the hit test on the cycle after CfgWe.
- Reset is asynchronous. Deassertion is synchronised externally, and the first valid cycle follows deassertion.
- Mid-frame config changes are permitted. Tearing is acceptable.

## Structure
- Shared package vga_pkg holds H_ACTIVE, V_ACTIVE, COORD_W and the sprite config record type (position, size, deltas, colour). The driver and client import the same constants.
- Sub-module sprite_slot is instantiated NUM_SPRITES times by generate. It contains the slot registers, motion update and hit test.
- The top contains the priority encoder, popcount, output registers and the FrameCollision flag.

## Test plan
- Slot 0 loaded at (0,0), size 14×20, del (6,4), colour (0,15,0); three Ticks -> position (6,4), (12,8), (18,12); pixel (18,12) gives GREEN=15, Hit=1, HitIdx=0 one cycle later.
- Slot 1 at x=620, size 14, delX=6, dirX=0; Tick -> x=626, dirX=1; Tick -> x=620. Slot at x=3, dirX=1, delX=6; Tick -> x=0, dirX=0.
- Slots 0 (red 15) and 2 (blue 15) both cover (100,100) -> RED=15, BLUE=0, HitIdx=0, Collision=1, FrameCollision=1; next Tick with no overlap clears FrameCollision.
- CfgWe with CfgIdx=NUM_SPRITES -> no slot changes; CfgWe and Tick on slot 0 in the same cycle -> slot 0 holds the config values unmoved.
- Blank=1 over a sprite -> Hit=0 and all colours 0.
- Reset driven low mid-frame with sprites active -> all outputs 0 immediately (asynchronous), all slots disabled; after release no Hit until reconfigured.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pkg : visible-area constants, sprite config record, axis step helper  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 11;
  localparam int SIZE_W   = 9;
  localparam int DEL_W    = 5;
  localparam int COLOR_W  = 4;
  localparam int AXIS_W   = COORD_W + 1;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SIZE_W-1:0]  x_size;
    logic [SIZE_W-1:0]  y_size;
    logic [DEL_W-1:0]   del_x;
    logic [DEL_W-1:0]   del_y;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } sprite_cfg_t;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               dir;
  } axis_t;

  // One bounce step along an axis; signed so a step past 0 clamps cleanly.
  function automatic axis_t axis_step(
    input logic [COORD_W-1:0] pos,
    input logic [SIZE_W-1:0]  size,
    input logic [DEL_W-1:0]   del,
    input logic               dir,
    input logic [COORD_W-1:0] limit
  );
    logic signed [AXIS_W-1:0] p, s, d, lim, n;
    axis_t r;
    p   = signed'({1'b0, pos});
    s   = signed'({{(AXIS_W-SIZE_W){1'b0}}, size});
    d   = signed'({{(AXIS_W-DEL_W){1'b0}}, del});
    lim = signed'({1'b0, limit}) - s;
    r.pos = pos;
    r.dir = dir;
    if (!dir) begin
      n = p + d;
      if (n >= lim) begin
        r.pos = lim[COORD_W-1:0];
        r.dir = 1'b1;
      end else begin
        r.pos = n[COORD_W-1:0];
      end
    end else begin
      n = p - d;
      if (n <= 0) begin
        r.pos = '0;
        r.dir = 1'b0;
      end else begin
        r.pos = n[COORD_W-1:0];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_slot : one sprite's registers, bounce motion and pixel hit test    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sprite_slot
  import vga_pkg::*;
#(
  parameter int H_MAX = H_ACTIVE,
  parameter int V_MAX = V_ACTIVE
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_we_i,
  input  logic                   tick_i,
  input  sprite_cfg_t            cfg_i,
  input  logic [COORD_W-1:0]     x_i,
  input  logic [COORD_W-1:0]     y_i,
  input  logic                   blank_i,
  output logic                   hit_o,
  output logic [3*COLOR_W-1:0]   rgb_o
);

  logic        en_q, en_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  sprite_cfg_t cfg_q, cfg_d;
  axis_t       w_step_x, w_step_y;
  logic [AXIS_W-1:0] w_x_end, w_y_end;

  assign w_step_x = axis_step(cfg_q.x, cfg_q.x_size, cfg_q.del_x, dir_x_q, COORD_W'(H_MAX));
  assign w_step_y = axis_step(cfg_q.y, cfg_q.y_size, cfg_q.del_y, dir_y_q, COORD_W'(V_MAX));

  // A load in the same cycle as a tick takes priority and suppresses the move.
  always_comb begin
    en_d    = en_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    cfg_d   = cfg_q;
    if (cfg_we_i) begin
      cfg_d   = cfg_i;
      en_d    = 1'b1;
      dir_x_d = 1'b0;
      dir_y_d = 1'b0;
    end else if (tick_i && en_q) begin
      cfg_d.x = w_step_x.pos;
      cfg_d.y = w_step_y.pos;
      dir_x_d = w_step_x.dir;
      dir_y_d = w_step_y.dir;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q    <= 1'b0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      cfg_q   <= '0;
    end else begin
      en_q    <= en_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      cfg_q   <= cfg_d;
    end
  end

  assign w_x_end = {1'b0, cfg_q.x} + {{(AXIS_W-SIZE_W){1'b0}}, cfg_q.x_size};
  assign w_y_end = {1'b0, cfg_q.y} + {{(AXIS_W-SIZE_W){1'b0}}, cfg_q.y_size};

  assign hit_o = en_q && !blank_i
              && (x_i >= cfg_q.x) && ({1'b0, x_i} < w_x_end)
              && (y_i >= cfg_q.y) && ({1'b0, y_i} < w_y_end);
  assign rgb_o = {cfg_q.red, cfg_q.green, cfg_q.blue};

endmodule
`default_nettype wire

// File: rtl/sprite_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_engine : NUM_SPRITES bouncing rectangles, priority compositing     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int COLOR_W     = vga_pkg::COLOR_W,
  parameter int COORD_W     = vga_pkg::COORD_W,
  parameter int SIZE_W      = vga_pkg::SIZE_W,
  parameter int DEL_W       = vga_pkg::DEL_W,
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE
) (
  input  logic               CLK_100MHz,
  input  logic               Reset,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               Blank,
  input  logic               Tick,
  input  logic               CfgWe,
  input  logic [3:0]         CfgIdx,
  input  logic [COORD_W-1:0] CfgX,
  input  logic [COORD_W-1:0] CfgY,
  input  logic [SIZE_W-1:0]  CfgXSize,
  input  logic [SIZE_W-1:0]  CfgYSize,
  input  logic [DEL_W-1:0]   CfgDelX,
  input  logic [DEL_W-1:0]   CfgDelY,
  input  logic [COLOR_W-1:0] CfgRed,
  input  logic [COLOR_W-1:0] CfgGreen,
  input  logic [COLOR_W-1:0] CfgBlue,
  output logic [COLOR_W-1:0] RED,
  output logic [COLOR_W-1:0] GREEN,
  output logic [COLOR_W-1:0] BLUE,
  output logic               Hit,
  output logic [3:0]         HitIdx,
  output logic               Collision,
  output logic               FrameCollision
);

  vga_pkg::sprite_cfg_t     w_cfg;
  logic [NUM_SPRITES-1:0]   w_hits;
  logic [3*COLOR_W-1:0]     w_rgb [NUM_SPRITES];
  logic                     w_any;
  logic [3:0]               w_idx;
  logic [3*COLOR_W-1:0]     w_sel;
  logic [4:0]               w_cnt;
  logic                     w_coll;

  logic [3*COLOR_W-1:0]     rgb_q;
  logic                     hit_q, coll_q, fcoll_q;
  logic [3:0]               idx_q;

  always_comb begin
    w_cfg        = '0;
    w_cfg.x      = CfgX;
    w_cfg.y      = CfgY;
    w_cfg.x_size = CfgXSize;
    w_cfg.y_size = CfgYSize;
    w_cfg.del_x  = CfgDelX;
    w_cfg.del_y  = CfgDelY;
    w_cfg.red    = CfgRed;
    w_cfg.green  = CfgGreen;
    w_cfg.blue   = CfgBlue;
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
    sprite_slot #(
      .H_MAX (H_ACTIVE),
      .V_MAX (V_ACTIVE)
    ) u_slot (
      .clk_i    (CLK_100MHz),
      .rst_ni   (Reset),
      .cfg_we_i (CfgWe && (CfgIdx == 4'(i))),
      .tick_i   (Tick),
      .cfg_i    (w_cfg),
      .x_i      (X),
      .y_i      (Y),
      .blank_i  (Blank),
      .hit_o    (w_hits[i]),
      .rgb_o    (w_rgb[i])
    );
  end

  // Scan high to low so the lowest hitting index is the last one written.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_sel = '0;
    w_cnt = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hits[i]) begin
        w_any = 1'b1;
        w_idx = 4'(i);
        w_sel = w_rgb[i];
      end
      w_cnt = w_cnt + {4'd0, w_hits[i]};
    end
    w_coll = (w_cnt >= 5'd2);
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      rgb_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      coll_q  <= 1'b0;
      fcoll_q <= 1'b0;
    end else begin
      rgb_q   <= w_sel;
      hit_q   <= w_any;
      idx_q   <= w_idx;
      coll_q  <= w_coll;
      fcoll_q <= w_coll | (fcoll_q & ~Tick);
    end
  end

  assign RED            = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign GREEN          = rgb_q[2*COLOR_W-1:COLOR_W];
  assign BLUE           = rgb_q[COLOR_W-1:0];
  assign Hit            = hit_q;
  assign HitIdx         = idx_q;
  assign Collision      = coll_q;
  assign FrameCollision = fcoll_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sprite_engine : directed self-checking bench for sprite_engine        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sprite_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] X, Y, CfgX, CfgY;
  logic        Blank, Tick, CfgWe;
  logic [3:0]  CfgIdx;
  logic [8:0]  CfgXSize, CfgYSize;
  logic [4:0]  CfgDelX, CfgDelY;
  logic [3:0]  CfgRed, CfgGreen, CfgBlue;
  logic [3:0]  RED, GREEN, BLUE, HitIdx;
  logic        Hit, Collision, FrameCollision;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sprite_engine dut (
    .CLK_100MHz(clk), .Reset(rst_n), .X(X), .Y(Y), .Blank(Blank), .Tick(Tick),
    .CfgWe(CfgWe), .CfgIdx(CfgIdx), .CfgX(CfgX), .CfgY(CfgY),
    .CfgXSize(CfgXSize), .CfgYSize(CfgYSize), .CfgDelX(CfgDelX), .CfgDelY(CfgDelY),
    .CfgRed(CfgRed), .CfgGreen(CfgGreen), .CfgBlue(CfgBlue),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .Hit(Hit), .HitIdx(HitIdx),
    .Collision(Collision), .FrameCollision(FrameCollision)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_px(input string tag, input logic hit, input logic [3:0] idx,
                        input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                        input logic coll);
    chk({tag, ".hit"}, {31'd0, Hit}, {31'd0, hit});
    chk({tag, ".idx"}, {28'd0, HitIdx}, {28'd0, idx});
    chk({tag, ".red"}, {28'd0, RED}, {28'd0, r});
    chk({tag, ".green"}, {28'd0, GREEN}, {28'd0, g});
    chk({tag, ".blue"}, {28'd0, BLUE}, {28'd0, b});
    chk({tag, ".coll"}, {31'd0, Collision}, {31'd0, coll});
  endtask

  task automatic pix(input int x, input int y, input logic b);
    @(negedge clk);
    X = 11'(x); Y = 11'(y); Blank = b;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_at(input int x, input int y);
    @(negedge clk);
    X = 11'(x); Y = 11'(y); Blank = 1'b0; Tick = 1'b1;
    @(posedge clk);
    #1;
    Tick = 1'b0;
  endtask

  task automatic cfg(input int idx, input int x, input int y, input int xs, input int ys,
                     input int dx, input int dy, input int r, input int g, input int b,
                     input logic tk);
    @(negedge clk);
    CfgIdx = 4'(idx); CfgX = 11'(x); CfgY = 11'(y);
    CfgXSize = 9'(xs); CfgYSize = 9'(ys); CfgDelX = 5'(dx); CfgDelY = 5'(dy);
    CfgRed = 4'(r); CfgGreen = 4'(g); CfgBlue = 4'(b);
    CfgWe = 1'b1; Tick = tk;
    @(negedge clk);
    CfgWe = 1'b0; Tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; X = '0; Y = '0; Blank = 1'b0; Tick = 1'b0; CfgWe = 1'b0;
    CfgIdx = '0; CfgX = '0; CfgY = '0; CfgXSize = '0; CfgYSize = '0;
    CfgDelX = '0; CfgDelY = '0; CfgRed = '0; CfgGreen = '0; CfgBlue = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_px("reset", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("reset.fcoll", {31'd0, FrameCollision}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Slot 3 bounce off right edge, then back down to the left edge
    cfg(3, 627, 300, 7, 5, 6, 0, 1, 2, 3, 1'b0);
    pix(627, 300, 1'b0); chk_px("s3.load", 1'b1, 4'd3, 4'd1, 4'd2, 4'd3, 1'b0);
    pix(626, 300, 1'b0); chk("s3.load.left", {31'd0, Hit}, 32'd0);
    tick_at(0, 479);
    pix(633, 300, 1'b0); chk("s3.clampR", {31'd0, Hit}, 32'd1);
    pix(639, 300, 1'b0); chk("s3.clampR.last", {31'd0, Hit}, 32'd1);
    pix(632, 300, 1'b0); chk("s3.clampR.left", {31'd0, Hit}, 32'd0);
    repeat (105) tick_at(0, 479);
    pix(3, 300, 1'b0); chk("s3.x3", {31'd0, Hit}, 32'd1);
    pix(2, 300, 1'b0); chk("s3.x3.left", {31'd0, Hit}, 32'd0);
    tick_at(0, 479);
    pix(0, 300, 1'b0); chk("s3.clampL", {31'd0, Hit}, 32'd1);
    tick_at(0, 479);
    pix(6, 300, 1'b0); chk("s3.x6", {31'd0, Hit}, 32'd1);
    pix(5, 300, 1'b0); chk("s3.x6.left", {31'd0, Hit}, 32'd0);

    // Slot 0 diagonal motion
    cfg(0, 0, 0, 14, 20, 6, 4, 0, 15, 0, 1'b0);
    pix(0, 0, 1'b0); chk_px("s0.load", 1'b1, 4'd0, 4'd0, 4'd15, 4'd0, 1'b0);
    tick_at(639, 479);
    pix(6, 4, 1'b0); chk("s0.t1", {31'd0, Hit}, 32'd1);
    pix(5, 4, 1'b0); chk("s0.t1.left", {31'd0, Hit}, 32'd0);
    pix(6, 3, 1'b0); chk("s0.t1.above", {31'd0, Hit}, 32'd0);
    tick_at(639, 479);
    pix(12, 8, 1'b0); chk("s0.t2", {31'd0, Hit}, 32'd1);
    pix(11, 8, 1'b0); chk("s0.t2.left", {31'd0, Hit}, 32'd0);
    tick_at(639, 479);
    pix(18, 12, 1'b0); chk_px("s0.t3", 1'b1, 4'd0, 4'd0, 4'd15, 4'd0, 1'b0);
    pix(31, 31, 1'b0); chk("s0.t3.corner", {31'd0, Hit}, 32'd1);
    pix(32, 31, 1'b0); chk("s0.t3.xend", {31'd0, Hit}, 32'd0);
    pix(31, 32, 1'b0); chk("s0.t3.yend", {31'd0, Hit}, 32'd0);
    pix(17, 12, 1'b0); chk("s0.t3.left", {31'd0, Hit}, 32'd0);

    // Slot 1 right-edge bounce
    cfg(1, 620, 100, 14, 10, 6, 0, 7, 0, 0, 1'b0);
    pix(620, 100, 1'b0); chk_px("s1.load", 1'b1, 4'd1, 4'd7, 4'd0, 4'd0, 1'b0);
    tick_at(0, 479);
    pix(626, 100, 1'b0); chk("s1.bounce", {31'd0, Hit}, 32'd1);
    pix(625, 100, 1'b0); chk("s1.bounce.left", {31'd0, Hit}, 32'd0);
    tick_at(0, 479);
    pix(620, 100, 1'b0); chk("s1.back", {31'd0, Hit}, 32'd1);
    pix(619, 100, 1'b0); chk("s1.back.left", {31'd0, Hit}, 32'd0);

    // Overlap, priority and sticky frame collision
    cfg(0, 90, 90, 20, 20, 0, 0, 15, 0, 0, 1'b0);
    cfg(2, 95, 95, 20, 20, 0, 0, 0, 0, 15, 1'b0);
    pix(100, 100, 1'b0); chk_px("ovl", 1'b1, 4'd0, 4'd15, 4'd0, 4'd0, 1'b1);
    chk("ovl.fcoll", {31'd0, FrameCollision}, 32'd1);
    pix(110, 110, 1'b0); chk_px("ovl.s2only", 1'b1, 4'd2, 4'd0, 4'd0, 4'd15, 1'b0);
    chk("ovl.sticky", {31'd0, FrameCollision}, 32'd1);
    tick_at(100, 100);
    chk("ovl.setwins", {31'd0, FrameCollision}, 32'd1);
    tick_at(200, 200);
    chk("ovl.cleared", {31'd0, FrameCollision}, 32'd0);
    chk("ovl.cleared.hit", {31'd0, Hit}, 32'd0);

    // Out-of-range index ignored; same-cycle load and tick
    cfg(4, 0, 0, 40, 40, 0, 0, 15, 15, 15, 1'b0);
    pix(0, 0, 1'b0); chk_px("badidx", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    pix(100, 100, 1'b0); chk_px("badidx.s0", 1'b1, 4'd0, 4'd15, 4'd0, 4'd0, 1'b1);
    cfg(0, 200, 200, 10, 10, 5, 5, 0, 9, 0, 1'b1);
    pix(200, 200, 1'b0); chk_px("cfgtick", 1'b1, 4'd0, 4'd0, 4'd9, 4'd0, 1'b0);
    pix(209, 209, 1'b0); chk("cfgtick.corner", {31'd0, Hit}, 32'd1);
    pix(210, 200, 1'b0); chk("cfgtick.xend", {31'd0, Hit}, 32'd0);

    // Blanking suppresses the hit
    pix(200, 200, 1'b1); chk_px("blank", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    pix(200, 200, 1'b0); chk("unblank", {31'd0, Hit}, 32'd1);

    // Asynchronous mid-frame reset
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_px("areset", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pix(200, 200, 1'b0); chk("postrst.s0", {31'd0, Hit}, 32'd0);
    pix(100, 100, 1'b0); chk_px("postrst.ovl", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("postrst.fcoll", {31'd0, FrameCollision}, 32'd0);
    pix(620, 100, 1'b0); chk("postrst.s1", {31'd0, Hit}, 32'd0);
    cfg(0, 50, 50, 4, 4, 0, 0, 3, 3, 3, 1'b0);
    pix(50, 50, 1'b0); chk_px("reload", 1'b1, 4'd0, 4'd3, 4'd3, 4'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
